// File: rtl/mul_chain_feeder.sv
// Chained-multiply operand feeder: buffers up to 8 float operands, streams
// n_mul+1 of them to a multiplier over a stb/ack handshake, then captures
// the single product the multiplier returns.
module mul_chain_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic [2:0]  n_mul,
  output logic        mul_stb,
  input  logic        mul_ack,
  output logic [31:0] mul_data,
  output logic [2:0]  cnt_max,
  input  logic        z_stb,
  input  logic [31:0] z_data,
  output logic        z_ack,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic [3:0]  fill,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StSend, StWaitZ} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem [8];
  logic [2:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]  fill_q;
  logic [2:0]  sent_q;
  logic [2:0]  cnt_max_q;
  logic [31:0] result_q;
  logic        result_valid_q;
  logic        err_q;

  logic idle, start_ok, accept, reject, push, drop, xfer, last_xfer, z_done;

  // Decode handshakes; start is judged on the fill value before any same-cycle push.
  always_comb begin
    idle      = (state_q == StIdle);
    start_ok  = (n_mul != 3'd0) && (fill_q >= ({1'b0, n_mul} + 4'd1));
    accept    = idle && start && start_ok;
    reject    = idle && start && !start_ok;
    push      = idle && wr_en && (fill_q != 4'd8);
    drop      = wr_en && !push;
    xfer      = (state_q == StSend) && mul_ack;
    last_xfer = xfer && (sent_q == cnt_max_q);
    z_done    = (state_q == StWaitZ) && z_stb;
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Controller next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept)    state_d = StSend;
      StSend:  if (last_xfer) state_d = StWaitZ;
      StWaitZ: if (z_done)    state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Controller outputs; all decode to 0 in IDLE so reset clears them at once.
  always_comb begin
    mul_stb  = (state_q == StSend);
    mul_data = (state_q == StSend) ? mem[rd_ptr_q] : 32'd0;
    z_ack    = (state_q == StWaitZ);
    busy     = !idle;
  end

  // Operand storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers, fill, transfer count, run length and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= 3'd0;
      rd_ptr_q       <= 3'd0;
      fill_q         <= 4'd0;
      sent_q         <= 3'd0;
      cnt_max_q      <= 3'd0;
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // Push only happens in IDLE and pop only in SEND, so they never collide.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 3'd1;
        fill_q   <= fill_q + 4'd1;
      end else if (xfer) begin
        rd_ptr_q <= rd_ptr_q + 3'd1;
        fill_q   <= fill_q - 4'd1;
      end
      if (accept) begin
        sent_q    <= 3'd0;
        cnt_max_q <= n_mul;
      end else if (xfer) begin
        sent_q <= sent_q + 3'd1;
      end
      if (z_done) result_q <= z_data;
      result_valid_q <= z_done;
      err_q          <= reject || drop;
    end
  end

  assign cnt_max      = cnt_max_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign fill         = fill_q;
  assign err          = err_q;

endmodule
